// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit, active-low 7-segment hex display.
// Steps through digits 0..3. Each digit is driven for DWELL_CYCLES and is
// followed by a BLANK_CYCLES gap with every anode off, so the previous digit
// does not ghost onto the next one. The display value is double-buffered:
// it is committed only at a frame boundary, which prevents tearing.
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   en           scan enable (0 keeps the display dark)
//   data_in      16-bit hex value; [3:0] is the rightmost digit
//   load         one-cycle strobe that captures data_in into the pending buffer
//   upd          one-cycle pulse when a new value is committed to active_val
//   frame_start  one-cycle pulse on entry to BLANK for digit 0
//   an           active-low anode enables
//   seg          active-low cathodes {g,f,e,d,c,b,a}
//   active_val   value currently on the display
module seg_scan_ctrl #(
  parameter int DWELL_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int LZB          = 1,
  parameter int CNT_W        = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] data_in,
  input  logic        load,
  output logic        upd,
  output logic        frame_start,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic [15:0] active_val
);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  state_t           state, state_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic             boundary;
  logic [15:0]      pending;
  logic             pend_v;
  logic [3:0]       an_nxt;
  logic [6:0]       seg_nxt;

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // A digit is a leading zero when it and every digit to its left are zero.
  function automatic logic digit_blank(input logic [15:0] v, input logic [1:0] k);
    logic b;
    b = 1'b0;
    if (LZB != 0) begin
      case (k)
        2'd1:    b = (v[15:4]  == 12'h000);
        2'd2:    b = (v[15:8]  == 8'h00);
        2'd3:    b = (v[15:12] == 4'h0);
        default: b = 1'b0;
      endcase
    end
    return b;
  endfunction

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    boundary  = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_nxt = BLANK;
          idx_nxt   = 2'd0;
          boundary  = 1'b1;
        end
      end
      BLANK: begin
        if (!en) begin
          state_nxt = IDLE;
          idx_nxt   = 2'd0;
        end else if (timer == BLANK_LAST) begin
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (!en) begin
          state_nxt = IDLE;
          idx_nxt   = 2'd0;
        end else if (timer == DWELL_LAST) begin
          state_nxt = BLANK;
          idx_nxt   = idx + 2'd1;
          boundary  = (idx == 2'd3);
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = 2'd0;
      end
    endcase

    // Every transition is a state entry, so the timer restarts from zero.
    if (state_nxt != state || state == IDLE) timer_nxt = '0;
    else                                     timer_nxt = timer + CNT_W'(1);

    // Outputs are computed for the upcoming state so they register on the
    // same edge as the state. active_val is only committed on entry to BLANK,
    // so its current value is already the one the next DRIVE must show.
    an_nxt  = 4'hF;
    seg_nxt = 7'h7F;
    if (state_nxt == DRIVE && !digit_blank(active_val, idx_nxt)) begin
      an_nxt  = ~(4'b0001 << idx_nxt);
      seg_nxt = hex2seg(active_val[{idx_nxt, 2'b00} +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= 2'd0;
      timer       <= '0;
      active_val  <= 16'h0000;
      pending     <= 16'h0000;
      pend_v      <= 1'b0;
      an          <= 4'hF;
      seg         <= 7'h7F;
      upd         <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      timer       <= timer_nxt;
      an          <= an_nxt;
      seg         <= seg_nxt;
      frame_start <= boundary;
      upd         <= boundary && (load || pend_v);
      if (load) begin
        pending <= data_in;
        pend_v  <= 1'b1;
      end
      // A load on the boundary cycle goes straight to the display.
      if (boundary) begin
        if (load)        active_val <= data_in;
        else if (pend_v) active_val <= pending;
        pend_v <= 1'b0;
      end
    end
  end

endmodule
